// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared pipeline definitions for the instruction fetch stage:
//   - DEFAULT_RESET_PC / DEFAULT_NOP_INSTR : parameter defaults
//   - fetch_state_t : fetch FSM states (BOOT, RUN)
//   - if_id_t       : contents of the IF/ID pipeline register
//   - make_bubble   : builds the IF/ID value used for a pipeline bubble
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'hBFC00000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h00000013;  // addi x0,x0,0

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // A bubble carries the NOP encoding with zeroed PCs and valid cleared.
    function automatic if_id_t make_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc       = 32'h0;
        b.pc_plus4 = 32'h0;
        b.valid    = 1'b0;
        return b;
    endfunction

    // Instruction fetches are word aligned; the low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with clear and enable.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, loads BUBBLE
//   en     : load d on the rising edge
//   clr    : load BUBBLE on the rising edge (wins over en)
//   d      : next register contents
//   q      : registered contents
// ---------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter type T      = if_id_t,
    parameter T    BUBBLE = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (clr) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: program counter, BOOT/RUN sequencing, IF/ID
// register, misaligned-redirect flag and accepted-instruction counter.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall_i           : hold PC and IF/ID
//   flush_i           : turn IF/ID into a bubble
//   redirect_i        : load redirect_pc_i (word aligned) into the PC
//   redirect_pc_i     : branch / jump target
//   instr_rd_i        : instruction word for instr_addr_o (combinational memory)
//   instr_addr_o      : current fetch address (PC_F)
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o : IF/ID register contents
//   misalign_o        : one-cycle pulse after a redirect with non-zero low bits
//   fetch_count_o     : valid instructions accepted into IF/ID (wraps)
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] instr_rd_i,
    output logic [31:0] instr_addr_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc_plus4_d_o,
    output logic        valid_d_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);

    localparam if_id_t BUBBLE = make_bubble(NOP_INSTR);

    fetch_state_t state;
    logic [31:0]  pc_p0;
    logic [31:0]  pc_plus4_p0;
    logic         in_run;
    logic         if_id_en;
    logic         if_id_clr;
    logic         accept;
    if_id_t       if_id_d;
    if_id_t       if_id_p1;

    assign pc_plus4_p0  = pc_p0 + 32'd4;   // modulo 2^32, no carry out
    assign instr_addr_o = pc_p0;

    // Control inputs only take effect once the FSM has left BOOT.
    assign in_run    = (state == RUN);
    assign if_id_clr = in_run & (redirect_i | flush_i);
    assign if_id_en  = in_run & ~stall_i;
    assign accept    = in_run & ~redirect_i & ~flush_i & ~stall_i;

    always_comb begin
        if_id_d          = BUBBLE;
        if_id_d.instr    = instr_rd_i;
        if_id_d.pc       = pc_p0;
        if_id_d.pc_plus4 = pc_plus4_p0;
        if_id_d.valid    = 1'b1;
    end

    // ---- stage F: PC, FSM, misalign flag, counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_p0         <= RESET_PC;
            misalign_o    <= 1'b0;
            fetch_count_o <= 32'h0;
        end else begin
            misalign_o <= 1'b0;
            if (state == BOOT) begin
                // BOOT edge: PC stays at RESET_PC so it is fetched on the next edge.
                state <= RUN;
            end else begin
                if (redirect_i) begin
                    pc_p0      <= word_align(redirect_pc_i);
                    misalign_o <= |redirect_pc_i[1:0];
                end else if (!stall_i) begin
                    pc_p0 <= pc_plus4_p0;
                end
                if (accept) begin
                    fetch_count_o <= fetch_count_o + 32'd1;
                end
            end
        end
    end

    // ---- stage F -> D: IF/ID register ----
    if_id_reg #(
        .T      (if_id_t),
        .BUBBLE (BUBBLE)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (if_id_en),
        .clr   (if_id_clr),
        .d     (if_id_d),
        .q     (if_id_p1)
    );

    assign instr_d_o    = if_id_p1.instr;
    assign pc_d_o       = if_id_p1.pc;
    assign pc_plus4_d_o = if_id_p1.pc_plus4;
    assign valid_d_o    = if_id_p1.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the fetch stage.
// The instruction memory returns addr ^ 32'hA5A5A5A5.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RPC  = 32'hBFC00000;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] MASK = 32'hA5A5A5A5;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_rd_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic        valid_d_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    int n_checks;
    int n_fail;

    // Behavioural model state
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_d;
    logic [31:0] m_pc4_d;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_cnt;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_rd_i    (instr_rd_i),
        .instr_addr_o  (instr_addr_o),
        .instr_d_o     (instr_d_o),
        .pc_d_o        (pc_d_o),
        .pc_plus4_d_o  (pc_plus4_d_o),
        .valid_d_o     (valid_d_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    assign instr_rd_i = instr_addr_o ^ MASK;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
    endtask

    task automatic do_reset();
        clear_ctrl();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_step();
        logic [31:0] fetched;
        fetched = m_pc ^ MASK;
        if (m_boot) begin
            m_boot = 1'b0;
            m_mis  = 1'b0;
        end else begin
            m_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i || flush_i) begin
                m_instr = NOP; m_pc_d = 0; m_pc4_d = 0; m_valid = 0;
            end else if (!stall_i) begin
                m_instr = fetched; m_pc_d = m_pc; m_pc4_d = m_pc + 4; m_valid = 1;
                m_cnt   = m_cnt + 1;
            end
            if (redirect_i)    m_pc = redirect_pc_i & 32'hFFFFFFFC;
            else if (!stall_i) m_pc = m_pc + 4;
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_pc = RPC; m_instr = NOP; m_pc_d = 0; m_pc4_d = 0;
        m_valid = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic test_reset();
        clear_ctrl();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (instr_addr_o !== RPC) begin
            n_fail++; $display("FAIL reset_addr got %h expected %h", instr_addr_o, RPC);
        end
        n_checks++;
        if ({instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o} !== {NOP, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_ifid got %h/%h/%h/%b expected bubble", instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o);
        end
        n_checks++;
        if ({misalign_o, fetch_count_o} !== 33'h0) begin
            n_fail++; $display("FAIL reset_flags got mis=%b cnt=%0d expected 0/0", misalign_o, fetch_count_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        do_reset();
        tick();  // BOOT edge
        n_checks++;
        if (instr_addr_o !== RPC || valid_d_o !== 1'b0) begin
            n_fail++; $display("FAIL boot_edge got addr=%h valid=%b expected %h/0", instr_addr_o, valid_d_o, RPC);
        end
        tick();
        n_checks++;
        if (valid_d_o !== 1'b1 || pc_d_o !== RPC || instr_d_o !== (RPC ^ MASK) || pc_plus4_d_o !== RPC + 4) begin
            n_fail++; $display("FAIL first_fetch got v=%b pc=%h instr=%h pc4=%h expected 1/%h/%h/%h",
                               valid_d_o, pc_d_o, instr_d_o, pc_plus4_d_o, RPC, RPC ^ MASK, RPC + 4);
        end
        n_checks++;
        if (instr_addr_o !== RPC + 4) begin
            n_fail++; $display("FAIL free_addr1 got %h expected %h", instr_addr_o, RPC + 4);
        end
        tick();
        tick();
        n_checks++;
        if (instr_addr_o !== RPC + 12 || pc_d_o !== RPC + 8 || fetch_count_o !== 32'd3) begin
            n_fail++; $display("FAIL free_run4 got addr=%h pc=%h cnt=%0d expected %h/%h/3",
                               instr_addr_o, pc_d_o, fetch_count_o, RPC + 12, RPC + 8);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (instr_addr_o !== RPC + 8 || pc_d_o !== RPC + 4 || valid_d_o !== 1'b1 || fetch_count_o !== 32'd2) begin
                n_fail++; $display("FAIL stall_hold[%0d] got addr=%h pc=%h v=%b cnt=%0d expected %h/%h/1/2",
                                   i, instr_addr_o, pc_d_o, valid_d_o, fetch_count_o, RPC + 8, RPC + 4);
            end
        end
        stall_i = 1'b0;
        tick();
        n_checks++;
        if (instr_addr_o !== RPC + 12 || pc_d_o !== RPC + 8 || fetch_count_o !== 32'd3) begin
            n_fail++; $display("FAIL stall_release got addr=%h pc=%h cnt=%0d expected %h/%h/3",
                               instr_addr_o, pc_d_o, fetch_count_o, RPC + 12, RPC + 8);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        repeat (2) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'hBFC00100; stall_i = 1'b1;
        tick();
        clear_ctrl();
        n_checks++;
        if (instr_addr_o !== 32'hBFC00100 || valid_d_o !== 1'b0 || fetch_count_o !== 32'd1 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL redirect_stall got addr=%h v=%b cnt=%0d mis=%b expected BFC00100/0/1/0",
                               instr_addr_o, valid_d_o, fetch_count_o, misalign_o);
        end
        tick();
        n_checks++;
        if (pc_d_o !== 32'hBFC00100 || valid_d_o !== 1'b1 || instr_d_o !== (32'hBFC00100 ^ MASK)) begin
            n_fail++; $display("FAIL redirect_target got pc=%h v=%b instr=%h expected BFC00100/1/%h",
                               pc_d_o, valid_d_o, instr_d_o, 32'hBFC00100 ^ MASK);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        repeat (2) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'hBFC00102;
        tick();
        clear_ctrl();
        n_checks++;
        if (instr_addr_o !== 32'hBFC00100 || misalign_o !== 1'b1) begin
            n_fail++; $display("FAIL misalign_set got addr=%h mis=%b expected BFC00100/1", instr_addr_o, misalign_o);
        end
        tick();
        n_checks++;
        if (misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse got %b expected 0", misalign_o);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        repeat (3) tick();
        flush_i = 1'b1; stall_i = 1'b1;
        tick();
        clear_ctrl();
        n_checks++;
        if (valid_d_o !== 1'b0 || instr_d_o !== NOP || pc_d_o !== 32'h0 || instr_addr_o !== RPC + 8 || fetch_count_o !== 32'd2) begin
            n_fail++; $display("FAIL flush_stall got v=%b instr=%h pc=%h addr=%h cnt=%0d expected 0/%h/0/%h/2",
                               valid_d_o, instr_d_o, pc_d_o, instr_addr_o, fetch_count_o, NOP, RPC + 8);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        repeat (2) tick();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
        tick();
        clear_ctrl();
        tick();
        n_checks++;
        if (instr_addr_o !== 32'h0 || pc_d_o !== 32'hFFFFFFFC || pc_plus4_d_o !== 32'h0) begin
            n_fail++; $display("FAIL pc_wrap got addr=%h pc=%h pc4=%h expected 0/FFFFFFFC/0",
                               instr_addr_o, pc_d_o, pc_plus4_d_o);
        end
    endtask

    task automatic test_boot_ignore();
        stall_i = 1'b1; flush_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h00001002;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();  // BOOT edge with all controls asserted
        clear_ctrl();
        n_checks++;
        if (instr_addr_o !== RPC || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL boot_ignore got addr=%h mis=%b expected %h/0", instr_addr_o, misalign_o, RPC);
        end
        tick();
        n_checks++;
        if (pc_d_o !== RPC || valid_d_o !== 1'b1 || fetch_count_o !== 32'd1) begin
            n_fail++; $display("FAIL boot_first got pc=%h v=%b cnt=%0d expected %h/1/1", pc_d_o, valid_d_o, fetch_count_o, RPC);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) tick();
        stall_i = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;  // mid-cycle, no clock edge follows before the check
        #1;
        n_checks++;
        if (instr_addr_o !== RPC || valid_d_o !== 1'b0 || instr_d_o !== NOP || pc_d_o !== 32'h0 ||
            pc_plus4_d_o !== 32'h0 || fetch_count_o !== 32'h0 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got addr=%h v=%b instr=%h pc=%h cnt=%0d expected reset values",
                               instr_addr_o, valid_d_o, instr_d_o, pc_d_o, fetch_count_o);
        end
        clear_ctrl();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            stall_i    = (r < 25);
            r = int'($urandom_range(0, 99));
            flush_i    = (r < 12);
            r = int'($urandom_range(0, 99));
            redirect_i = (r < 10);
            redirect_pc_i = $urandom;
            model_step();
            tick();
            n_checks++;
            if (instr_addr_o !== m_pc) begin
                n_fail++; $display("FAIL rand_addr[%0d] got %h expected %h", i, instr_addr_o, m_pc);
            end
            n_checks++;
            if ({instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o} !== {m_instr, m_pc_d, m_pc4_d, m_valid}) begin
                n_fail++; $display("FAIL rand_ifid[%0d] got %h/%h/%h/%b expected %h/%h/%h/%b", i,
                                   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, m_instr, m_pc_d, m_pc4_d, m_valid);
            end
            n_checks++;
            if (misalign_o !== m_mis || fetch_count_o !== m_cnt) begin
                n_fail++; $display("FAIL rand_flags[%0d] got mis=%b cnt=%0d expected %b/%0d", i,
                                   misalign_o, fetch_count_o, m_mis, m_cnt);
            end
        end
        clear_ctrl();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        clear_ctrl();
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_flush_stall();
        test_pc_wrap();
        test_boot_ignore();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
